// File: rtl/stack_port_ctrl_pkg.sv
// Shared stack definitions: FSM state encoding and default stack bounds,
// used by the port controller, the pointer unit and the decoder.
package stack_port_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PUSH    = 3'd1,
      ST_POP_DEC = 3'd2,
      ST_POP_RD  = 3'd3,
      ST_POP_CAP = 3'd4,
      ST_FIN     = 3'd5
   } state_e;

   localparam logic [7:0] STACK_BASE_DEF  = 8'h00;
   localparam logic [7:0] STACK_LIMIT_DEF = 8'hFF;

endpackage

// File: rtl/stack_port_ctrl.sv
// Memory-side stack controller: sequences push (post-increment) and
// pop (pre-decrement) RAM transfers and drives the pointer strobes.
module stack_port_ctrl
   import stack_port_ctrl_pkg::*;
#(
   parameter logic [7:0] STACK_BASE  = STACK_BASE_DEF,
   parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_req,
   input  logic       pop_req,
   input  logic [7:0] data_in,
   input  logic [7:0] sp,
   output logic       sp_inc,
   output logic       sp_dec,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata,
   output logic [7:0] data_out,
   output logic       ready,
   output logic       done,
   output logic       err
);

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] dout_q, dout_d;
   logic       err_q, err_d;

   logic       sp_inc_c, sp_dec_c, we_c, re_c;
   logic       ready_c, done_c, err_c;
   logic [7:0] addr_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= 8'h00;
         addr_q  <= 8'h00;
         dout_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      err_d    = err_q;
      sp_inc_c = 1'b0;
      sp_dec_c = 1'b0;
      we_c     = 1'b0;
      re_c     = 1'b0;
      ready_c  = 1'b0;
      done_c   = 1'b0;
      err_c    = 1'b0;
      addr_c   = addr_q;
      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            // push has priority; a simultaneous pop is silently dropped
            if (push_req) begin
               if (sp == STACK_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  data_d  = data_in;
                  state_d = ST_PUSH;
               end
            end else if (pop_req) begin
               if (sp == STACK_BASE) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_POP_DEC;
               end
            end
         end
         ST_PUSH: begin
            addr_c   = sp;
            addr_d   = sp;
            we_c     = 1'b1;
            sp_inc_c = 1'b1;
            state_d  = ST_FIN;
         end
         ST_POP_DEC: begin
            sp_dec_c = 1'b1;
            state_d  = ST_POP_RD;
         end
         ST_POP_RD: begin
            addr_c  = sp;
            addr_d  = sp;
            re_c    = 1'b1;
            state_d = ST_POP_CAP;
         end
         ST_POP_CAP: begin
            dout_d  = mem_rdata;
            state_d = ST_FIN;
         end
         ST_FIN: begin
            done_c  = 1'b1;
            err_c   = err_q;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All control outputs are forced inactive while reset is held
   assign ready     = ready_c & ~reset;
   assign done      = done_c & ~reset;
   assign err       = err_c & ~reset;
   assign sp_inc    = sp_inc_c & ~reset;
   assign sp_dec    = sp_dec_c & ~reset;
   assign mem_we    = we_c & ~reset;
   assign mem_re    = re_c & ~reset;
   assign mem_addr  = reset ? 8'h00 : addr_c;
   assign mem_wdata = reset ? 8'h00 : data_q;
   assign data_out  = reset ? 8'h00 : dout_q;

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Directed bench for stack_port_ctrl with a pointer-unit and RAM model.
module tb_stack_port_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       push_req, pop_req;
   logic [7:0] data_in;
   logic [7:0] sp;
   logic       sp_inc, sp_dec;
   logic [7:0] mem_addr, mem_wdata;
   logic       mem_we, mem_re;
   logic [7:0] mem_rdata;
   logic [7:0] data_out;
   logic       ready, done, err;

   logic       sp_ld;
   logic [7:0] sp_ld_val;
   logic [7:0] ram [256];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   stack_port_ctrl dut (
      .clk(clk), .reset(reset),
      .push_req(push_req), .pop_req(pop_req),
      .data_in(data_in), .sp(sp),
      .sp_inc(sp_inc), .sp_dec(sp_dec),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .data_out(data_out),
      .ready(ready), .done(done), .err(err)
   );

   always @(posedge clk) begin
      if (sp_ld) sp <= sp_ld_val;
      else if (sp_inc) sp <= sp + 8'd1;
      else if (sp_dec) sp <= sp - 8'd1;
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load_sp(input logic [7:0] v);
      sp_ld = 1'b1;
      sp_ld_val = v;
      tick();
      sp_ld = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      push_req = 1'b0;
      pop_req = 1'b0;
      data_in = 8'h00;
      sp_ld = 1'b1;
      sp_ld_val = 8'h00;
      tick();
      tick();
      chk("rst_ready", {7'd0, ready}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      reset = 1'b0;
      sp_ld = 1'b0;
      tick();
      chk("post_rst_ready", {7'd0, ready}, 8'd1);
      chk("post_rst_dout", data_out, 8'h00);
      chk("post_rst_addr", mem_addr, 8'h00);
      chk("post_rst_wdata", mem_wdata, 8'h00);
      chk("post_rst_we", {7'd0, mem_we}, 8'd0);

      // push A5 at sp=10
      load_sp(8'h10);
      push_req = 1'b1;
      data_in = 8'hA5;
      tick();
      push_req = 1'b0;
      data_in = 8'h00;
      chk("push_we", {7'd0, mem_we}, 8'd1);
      chk("push_addr", mem_addr, 8'h10);
      chk("push_wdata", mem_wdata, 8'hA5);
      chk("push_inc", {7'd0, sp_inc}, 8'd1);
      chk("push_done_early", {7'd0, done}, 8'd0);
      tick();
      chk("push_done", {7'd0, done}, 8'd1);
      chk("push_err", {7'd0, err}, 8'd0);
      chk("push_we_off", {7'd0, mem_we}, 8'd0);
      chk("push_sp", sp, 8'h11);
      tick();
      chk("push_ready", {7'd0, ready}, 8'd1);

      // pop from sp=11
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      chk("pop_dec", {7'd0, sp_dec}, 8'd1);
      chk("pop_re_early", {7'd0, mem_re}, 8'd0);
      tick();
      chk("pop_re", {7'd0, mem_re}, 8'd1);
      chk("pop_addr", mem_addr, 8'h10);
      chk("pop_dec_off", {7'd0, sp_dec}, 8'd0);
      tick();
      chk("pop_cap_done", {7'd0, done}, 8'd0);
      tick();
      chk("pop_done", {7'd0, done}, 8'd1);
      chk("pop_err", {7'd0, err}, 8'd0);
      chk("pop_dout", data_out, 8'hA5);
      chk("pop_sp", sp, 8'h10);
      tick();

      // overflow
      load_sp(8'hFF);
      push_req = 1'b1;
      data_in = 8'h77;
      tick();
      push_req = 1'b0;
      chk("ovf_done", {7'd0, done}, 8'd1);
      chk("ovf_err", {7'd0, err}, 8'd1);
      chk("ovf_we", {7'd0, mem_we}, 8'd0);
      chk("ovf_inc", {7'd0, sp_inc}, 8'd0);
      chk("ovf_wdata_held", mem_wdata, 8'hA5);
      tick();
      chk("ovf_err_clr", {7'd0, err}, 8'd0);
      chk("ovf_sp", sp, 8'hFF);

      // underflow
      load_sp(8'h00);
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      chk("unf_done", {7'd0, done}, 8'd1);
      chk("unf_err", {7'd0, err}, 8'd1);
      chk("unf_dec", {7'd0, sp_dec}, 8'd0);
      chk("unf_re", {7'd0, mem_re}, 8'd0);
      chk("unf_dout", data_out, 8'hA5);
      tick();
      chk("unf_sp", sp, 8'h00);

      // simultaneous push and pop
      load_sp(8'h20);
      push_req = 1'b1;
      pop_req = 1'b1;
      data_in = 8'h3C;
      tick();
      push_req = 1'b0;
      pop_req = 1'b0;
      chk("both_we", {7'd0, mem_we}, 8'd1);
      chk("both_wdata", mem_wdata, 8'h3C);
      chk("both_addr", mem_addr, 8'h20);
      chk("both_dec", {7'd0, sp_dec}, 8'd0);
      tick();
      chk("both_done", {7'd0, done}, 8'd1);
      chk("both_err", {7'd0, err}, 8'd0);
      chk("both_dec2", {7'd0, sp_dec}, 8'd0);
      chk("both_sp", sp, 8'h21);
      tick();

      // reset while in POP_RD
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      tick();
      chk("mid_re", {7'd0, mem_re}, 8'd1);
      reset = 1'b1;
      tick();
      chk("mid_rst_ready", {7'd0, ready}, 8'd0);
      chk("mid_rst_re", {7'd0, mem_re}, 8'd0);
      reset = 1'b0;
      tick();
      chk("mid_ready", {7'd0, ready}, 8'd1);
      chk("mid_dout", data_out, 8'h00);
      chk("mid_done", {7'd0, done}, 8'd0);
      tick();
      chk("mid_no_cap_done", {7'd0, done}, 8'd0);
      chk("mid_ready2", {7'd0, ready}, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stack_port_ctrl.md
# stack_port_ctrl

Memory-side controller for the hardware stack. It accepts push/pop commands from the control unit and sequences the RAM write or read at the current stack pointer. It drives the pointer unit's increment/decrement strobes and reports overflow/underflow. It sits between the instruction decoder, the 8-bit stack pointer register and the byte-wide data RAM. The pointer unit owns the pointer value; this block owns every stack data transfer.

## Interface
Parameters:
- STACK_BASE, 8'h00, lowest stack address; stack is empty when sp == STACK_BASE
- STACK_LIMIT, 8'hFF, address one past the last usable entry; stack is full when sp == STACK_LIMIT

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns the FSM to IDLE and clears all outputs
- push_req  in  1  push command, sampled only while ready=1
- pop_req  in  1  pop command, sampled only while ready=1
- data_in  in  8  byte to push, captured in the accept cycle
- sp  in  8  current stack pointer from the pointer unit
- sp_inc  out  1  one-cycle strobe: pointer unit adds 1 at the next edge
- sp_dec  out  1  one-cycle strobe: pointer unit subtracts 1 at the next edge
- mem_addr  out  8  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; RAM returns mem_rdata one cycle later
- mem_rdata  in  8  RAM read data
- data_out  out  8  last popped byte, held until the next successful pop
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when a command finishes
- err  out  1  one-cycle pulse with done on overflow or underflow

## Operation
- States: IDLE, PUSH, POP_DEC, POP_RD, POP_CAP, FIN.
- IDLE: ready=1.
  - push_req=1 and sp == STACK_LIMIT: overflow. Go to FIN with err flagged. No RAM write, no strobe.
  - push_req=1 otherwise: latch data_in and go to PUSH.
  - pop_req=1 and sp == STACK_BASE: underflow. Go to FIN with err flagged.
  - pop_req=1 otherwise: go to POP_DEC.
  - push_req and pop_req both high: push wins and the pop is dropped (no error).
- PUSH: mem_addr=sp, mem_wdata=latched byte, mem_we=1, sp_inc=1. Write uses the pre-increment sp, so push is post-increment. Next state FIN.
- POP_DEC: sp_dec=1. Next state POP_RD. Pop is pre-decrement.
- POP_RD: mem_addr=sp (the decremented value), mem_re=1. Next state POP_CAP.
- POP_CAP: data_out <= mem_rdata. Next state FIN.
- FIN: done=1, err=latched error flag. Next state IDLE; the error flag clears.
- Outside the states listed above, mem_we, mem_re, sp_inc and sp_dec are 0 and mem_addr/mem_wdata hold their last values.
- No arithmetic on sp inside this block. Full and empty are equality compares only, so no wrap-around is ever requested.

## Timing
- Reset values: ready=0 during reset, 1 in the first cycle after. done=0, err=0, sp_inc=0, sp_dec=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, data_out=0.
- Push latency: accept edge → PUSH (1 cycle) → FIN. done asserts 2 cycles after accept.
- Pop latency: accept → POP_DEC → POP_RD → POP_CAP → FIN. done asserts 4 cycles after accept; data_out is valid in the FIN cycle.
- Error latency: accept → FIN. done and err assert 1 cycle after accept.
- Back-to-back: a new command can be accepted in the cycle after FIN.
- Reset mid-operation: the FSM returns to IDLE at that edge. Any pending strobe or write is not issued afterwards. The pointer unit is reset separately.
- Requests while ready=0 are ignored, not queued.

## Structure
- A shared stack package holds the state encoding (3-bit enumerated constants) and the default STACK_BASE/STACK_LIMIT values, so the pointer unit and the decoder use the same bounds.
- Single module; the FSM and output decode are inline. No sub-module is needed.

## Test plan
- Reset then push 8'hA5 with sp=8'h10: mem_we=1, mem_addr=8'h10, mem_wdata=8'hA5, sp_inc=1 for one cycle; done 2 cycles after accept; err=0.
- Pop with sp=8'h11, RAM[8'h10]=8'hA5: sp_dec pulse, then mem_re with mem_addr=8'h10; data_out=8'hA5 when done pulses 4 cycles after accept.
- Push with sp=STACK_LIMIT (8'hFF): no mem_we, no sp_inc; done=err=1 the next cycle.
- Pop with sp=STACK_BASE (8'h00): no sp_dec, no mem_re; done=err=1; data_out unchanged.
- push_req=pop_req=1 with data_in=8'h3C: push performed (mem_wdata=8'h3C); no sp_dec is ever issued.
- Reset asserted in POP_RD: no POP_CAP; data_out=0, ready=1 one cycle after reset deasserts.
